// File: rtl/edsac_pkg.sv
// Shared definitions for the EDSAC-style serial arithmetic units: word timing
// constants, the order encoding and the pulse-interval counter width.
package edsac_pkg;

  localparam int INTERVAL   = 36;
  localparam int WORD_BITS  = 35;
  localparam int SHORT_BITS = 17;

  function automatic int pi_width(input int modulus);
    return (modulus <= 2) ? 1 : $clog2(modulus);
  endfunction

  localparam int PI_W = pi_width(INTERVAL);

  typedef enum logic [1:0] {
    NONE = 2'd0,
    ADD  = 2'd1,
    SUB  = 2'd2
  } order_e;

  // Both enables high is treated as no order (pass-through), not an error.
  function automatic order_e decode_order(input logic add_en, input logic sub_en);
    if (add_en && !sub_en) return ADD;
    if (sub_en && !add_en) return SUB;
    return NONE;
  endfunction

endpackage

// File: rtl/serial_adder_unit_pulse_counter.sv
// Modulo-MODULUS pulse-interval counter; mc_start marks p.i. 0 and reloads the
// count so the following interval is p.i. 1.
module pulse_counter #(
  parameter int MODULUS = 36,
  parameter int W       = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         mc_start,
  output logic [W-1:0] cnt,
  output logic         pi_zero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + W'(1);
    if (mc_start) begin
      cnt_d = W'(1);
    end else if (cnt_q == W'(MODULUS - 1)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt     = cnt_q;
  assign pi_zero = mc_start || (cnt_q == '0);

endmodule

// File: rtl/serial_adder_unit.sv
// Bit-serial adder/subtractor feeding the accumulator delay line, LSB first,
// with per-word order latch, short-operand sign extension and sticky overflow.
module serial_adder_unit
  import edsac_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            mc_start,
  input  logic            acc,
  input  logic            operand,
  input  logic            add_en,
  input  logic            sub_en,
  input  logic            long_op,
  input  logic            ovf_clr,
  output logic            adder_sum,
  output logic            carry,
  output logic            sign_out,
  output logic            overflow,
  output logic [PI_W-1:0] pi
);

  logic [PI_W-1:0] pi_cnt;
  logic            pi_zero;
  logic [PI_W-1:0] pi_eff;

  order_e ord_q, ord_d, ord_cur;
  logic   long_q, long_d, long_cur;
  logic   ssign_q, ssign_d;
  logic   carry_q, carry_d;
  logic   sign_q, sign_d;
  logic   ovf_q, ovf_d;

  logic active, at_sign, short_ext;
  logic b_raw, b, c_in, sum_c, c_out;

  pulse_counter #(
    .MODULUS(INTERVAL),
    .W      (PI_W)
  ) u_pulse_counter (
    .clk     (clk),
    .rst     (rst),
    .mc_start(mc_start),
    .cnt     (pi_cnt),
    .pi_zero (pi_zero)
  );

  // A resync pulse makes this interval p.i. 0 whatever the counter holds.
  assign pi_eff = mc_start ? '0 : pi_cnt;

  always_comb begin
    ord_cur   = pi_zero ? decode_order(add_en, sub_en) : ord_q;
    long_cur  = pi_zero ? long_op : long_q;
    active    = (pi_eff < PI_W'(WORD_BITS));
    at_sign   = (pi_eff == PI_W'(WORD_BITS - 1));
    short_ext = !long_cur && (pi_eff >= PI_W'(SHORT_BITS)) && active;

    b_raw = short_ext ? ssign_q : operand;
    case (ord_cur)
      ADD:     b = b_raw;
      SUB:     b = ~b_raw;
      default: b = 1'b0;
    endcase

    c_in  = pi_zero ? (ord_cur == SUB) : carry_q;
    sum_c = active ? (acc ^ b ^ c_in) : 1'b0;
    c_out = (acc & b) | (acc & c_in) | (b & c_in);

    ord_d   = ord_cur;
    long_d  = long_cur;
    ssign_d = (pi_eff == PI_W'(SHORT_BITS - 1)) ? operand : ssign_q;
    carry_d = active ? c_out : 1'b0;
    sign_d  = at_sign ? sum_c : sign_q;

    // A new overflow at the sign p.i. beats a simultaneous clear.
    ovf_d = ovf_q;
    if (at_sign && (c_in ^ c_out)) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ord_q   <= NONE;
      long_q  <= 1'b0;
      ssign_q <= 1'b0;
      carry_q <= 1'b0;
      sign_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      ord_q   <= ord_d;
      long_q  <= long_d;
      ssign_q <= ssign_d;
      carry_q <= carry_d;
      sign_q  <= sign_d;
      ovf_q   <= ovf_d;
    end
  end

  assign adder_sum = sum_c & ~rst;
  assign carry     = carry_q;
  assign sign_out  = sign_q;
  assign overflow  = ovf_q;
  assign pi        = pi_cnt;

endmodule

// File: tb/tb_serial_adder_unit.sv
// Self-checking bench for serial_adder_unit: words are streamed LSB-first and
// compared against an integer reference model through a scoreboard queue.
module tb_serial_adder_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mc_start = 1'b0;
  logic       acc = 1'b0;
  logic       operand = 1'b0;
  logic       add_en = 1'b0;
  logic       sub_en = 1'b0;
  logic       long_op = 1'b1;
  logic       ovf_clr = 1'b0;
  logic       adder_sum, carry, sign_out, overflow;
  logic [5:0] pi;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [34:0] sum;
    logic        ovf;
    logic        sign;
  } exp_t;
  exp_t exp_q[$];

  localparam logic [34:0] MAXPOS = 35'h3_FFFF_FFFF;

  serial_adder_unit dut (
    .clk(clk), .rst(rst), .mc_start(mc_start), .acc(acc), .operand(operand),
    .add_en(add_en), .sub_en(sub_en), .long_op(long_op), .ovf_clr(ovf_clr),
    .adder_sum(adder_sum), .carry(carry), .sign_out(sign_out),
    .overflow(overflow), .pi(pi)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [34:0] a, input logic [34:0] op,
                                 input logic add, input logic sub, input logic lng);
    exp_t e;
    logic [34:0] bv;
    bv = lng ? op : {{18{op[16]}}, op[16:0]};
    e.ovf = 1'b0;
    if (add && !sub) begin
      e.sum = a + bv;
      e.ovf = (a[34] == bv[34]) && (e.sum[34] != a[34]);
    end else if (sub && !add) begin
      e.sum = a - bv;
      e.ovf = (a[34] != bv[34]) && (e.sum[34] != a[34]);
    end else begin
      e.sum = a;
    end
    e.sign = e.sum[34];
    return e;
  endfunction

  task automatic stream_word(input logic [34:0] a, input logic [34:0] op,
                             input logic add, input logic sub, input logic lng,
                             input int clr_pi, output logic [34:0] sum,
                             output logic guard, output logic ovf_pre,
                             output logic ovf_post, output logic sign_post,
                             output logic carry_post);
    sum = '0;
    guard = 1'b0;
    ovf_pre = 1'b0;
    for (int i = 0; i < 36; i++) begin
      @(negedge clk);
      mc_start = (i == 0);
      acc      = (i < 35) ? a[i] : 1'b0;
      operand  = (i < 35) ? op[i] : 1'b0;
      add_en   = add;
      sub_en   = sub;
      long_op  = lng;
      ovf_clr  = (i == clr_pi);
      #1;
      if (i < 35) sum[i] = adder_sum;
      else guard = adder_sum;
      if (i == 34) ovf_pre = overflow;
    end
    @(posedge clk);
    #1;
    ovf_post   = overflow;
    sign_post  = sign_out;
    carry_post = carry;
    mc_start = 1'b0;
    ovf_clr  = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    acc = 1'b1;
    add_en = 1'b1;
    #1;
    n_vec++; if (pi !== 6'd0) begin n_err++; $display("FAIL reset_pi got=%0d want=0", pi); end
    n_vec++; if (carry !== 1'b0) begin n_err++; $display("FAIL reset_carry got=%b want=0", carry); end
    n_vec++; if (sign_out !== 1'b0) begin n_err++; $display("FAIL reset_sign got=%b want=0", sign_out); end
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf got=%b want=0", overflow); end
    n_vec++; if (adder_sum !== 1'b0) begin n_err++; $display("FAIL reset_sum got=%b want=0", adder_sum); end
    @(negedge clk);
    rst = 1'b0;
    acc = 1'b0;
    add_en = 1'b0;
  endtask

  task automatic run_check(input string name, input logic [34:0] a, input logic [34:0] op,
                           input logic add, input logic sub, input logic lng);
    logic [34:0] s;
    logic g, op_pre, op_post, sp, cp;
    exp_t e;
    exp_q.push_back(model(a, op, add, sub, lng));
    stream_word(a, op, add, sub, lng, -1, s, g, op_pre, op_post, sp, cp);
    e = exp_q.pop_front();
    n_vec++; if (s !== e.sum) begin n_err++; $display("FAIL %s_sum got=%h want=%h", name, s, e.sum); end
    n_vec++; if (sp !== e.sign) begin n_err++; $display("FAIL %s_sign got=%b want=%b", name, sp, e.sign); end
    n_vec++; if (op_post !== 1'b0) begin n_err++; $display("FAIL %s_ovf got=%b want=0", name, op_post); end
    n_vec++; if (g !== 1'b0) begin n_err++; $display("FAIL %s_guard_sum got=%b want=0", name, g); end
    n_vec++; if (cp !== 1'b0) begin n_err++; $display("FAIL %s_guard_carry got=%b want=0", name, cp); end
  endtask

  task automatic test_long_add;
    run_check("add5p3", 35'd5, 35'd3, 1'b1, 1'b0, 1'b1);
    run_check("add_mixed", 35'h1_2345_6789, 35'h0_0F0F_0F0F, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic test_long_sub;
    run_check("sub3m5", 35'd3, 35'd5, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_short_sext;
    run_check("short_m1", 35'd0, {18'h2AAAA, 17'h1FFFF}, 1'b1, 1'b0, 1'b0);
    run_check("short_sub", 35'd100, {18'h15555, 17'h0FFFF}, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_order_edges;
    run_check("both_en", 35'h5_A5A5_A5A5 & MAXPOS, 35'h1_1111_1111, 1'b1, 1'b1, 1'b1);
    run_check("none_en", 35'h0_CAFE_BABE, 35'h3_FFFF_FFFF, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_resync;
    logic [34:0] s;
    logic g, op_pre, op_post, sp, cp;
    stream_word(35'd3, 35'd5, 1'b0, 1'b1, 1'b1, -1, s, g, op_pre, op_post, sp, cp);
    n_vec++; if (sp !== 1'b1) begin n_err++; $display("FAIL resync_pre_sign got=%b want=1", sp); end
    for (int i = 0; i <= 20; i++) begin
      @(negedge clk);
      mc_start = (i == 0) || (i == 20);
      add_en = 1'b1; sub_en = 1'b0; long_op = 1'b1;
      acc = (i < 20);
      operand = (i == 0);
      #1;
      if (i == 19) begin
        n_vec++; if (carry !== 1'b1) begin n_err++; $display("FAIL resync_carry_pre got=%b want=1", carry); end
      end
    end
    n_vec++; if (adder_sum !== 1'b0) begin n_err++; $display("FAIL resync_sum got=%b want=0", adder_sum); end
    @(posedge clk); #1;
    n_vec++; if (pi !== 6'd1) begin n_err++; $display("FAIL resync_pi got=%0d want=1", pi); end
    n_vec++; if (carry !== 1'b0) begin n_err++; $display("FAIL resync_carry got=%b want=0", carry); end
    mc_start = 1'b0; acc = 1'b0; operand = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    n_vec++; if (pi !== 6'd21) begin n_err++; $display("FAIL resync_pi_run got=%0d want=21", pi); end
    n_vec++; if (sign_out !== 1'b1) begin n_err++; $display("FAIL resync_sign got=%b want=1", sign_out); end
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL resync_ovf got=%b want=0", overflow); end
  endtask

  task automatic test_overflow;
    logic [34:0] s;
    logic g, op_pre, op_post, sp, cp;
    exp_t e;
    exp_q.push_back(model(MAXPOS, 35'd1, 1'b1, 1'b0, 1'b1));
    stream_word(MAXPOS, 35'd1, 1'b1, 1'b0, 1'b1, -1, s, g, op_pre, op_post, sp, cp);
    e = exp_q.pop_front();
    n_vec++; if (s !== e.sum) begin n_err++; $display("FAIL ovf_sum got=%h want=%h", s, e.sum); end
    n_vec++; if (op_pre !== 1'b0) begin n_err++; $display("FAIL ovf_at_sign got=%b want=0", op_pre); end
    n_vec++; if (op_post !== e.ovf) begin n_err++; $display("FAIL ovf_set got=%b want=%b", op_post, e.ovf); end
    n_vec++; if (sp !== e.sign) begin n_err++; $display("FAIL ovf_sign got=%b want=%b", sp, e.sign); end
    for (int w = 0; w < 2; w++) begin
      stream_word(35'd0, 35'd0, 1'b1, 1'b0, 1'b1, -1, s, g, op_pre, op_post, sp, cp);
      n_vec++; if (op_post !== 1'b1) begin n_err++; $display("FAIL ovf_sticky%0d got=%b want=1", w, op_post); end
    end
    stream_word(35'd0, 35'd0, 1'b1, 1'b0, 1'b1, 0, s, g, op_pre, op_post, sp, cp);
    n_vec++; if (op_post !== 1'b0) begin n_err++; $display("FAIL ovf_clr got=%b want=0", op_post); end
    stream_word(MAXPOS, 35'd1, 1'b1, 1'b0, 1'b1, 34, s, g, op_pre, op_post, sp, cp);
    n_vec++; if (op_post !== 1'b1) begin n_err++; $display("FAIL ovf_set_wins got=%b want=1", op_post); end
  endtask

  task automatic test_reset_midcycle;
    for (int i = 0; i <= 10; i++) begin
      @(negedge clk);
      mc_start = (i == 0);
      add_en = 1'b1; sub_en = 1'b0; long_op = 1'b1;
      acc = 1'b1;
      operand = (i == 0);
      #1;
    end
    n_vec++; if (pi !== 6'd10) begin n_err++; $display("FAIL rstmid_pi_pre got=%0d want=10", pi); end
    n_vec++; if (carry !== 1'b1) begin n_err++; $display("FAIL rstmid_carry_pre got=%b want=1", carry); end
    rst = 1'b1;
    #1;
    n_vec++; if (pi !== 6'd0) begin n_err++; $display("FAIL rstmid_pi got=%0d want=0", pi); end
    n_vec++; if (carry !== 1'b0) begin n_err++; $display("FAIL rstmid_carry got=%b want=0", carry); end
    n_vec++; if (sign_out !== 1'b0) begin n_err++; $display("FAIL rstmid_sign got=%b want=0", sign_out); end
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL rstmid_ovf got=%b want=0", overflow); end
    n_vec++; if (adder_sum !== 1'b0) begin n_err++; $display("FAIL rstmid_sum got=%b want=0", adder_sum); end
    @(negedge clk);
    rst = 1'b0;
    mc_start = 1'b0;
    #1;
    n_vec++; if (pi !== 6'd0) begin n_err++; $display("FAIL rstrel_pi got=%0d want=0", pi); end
    @(posedge clk); #1;
    n_vec++; if (pi !== 6'd1) begin n_err++; $display("FAIL rstrel_pi_count got=%0d want=1", pi); end
  endtask

  initial begin
    test_reset();
    test_long_add();
    test_long_sub();
    test_short_sext();
    test_order_edges();
    test_resync();
    test_overflow();
    test_reset_midcycle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/serial_adder_unit.md
Name: serial_adder_unit

Overview:
- Bit-serial adder/subtractor (ASU I) that feeds the accumulator store.
- Takes the gated accumulator stream and the serial operand stream LSB-first.
- Produces the serial `adder_sum` that the accumulator writes back into its delay line.
- Keeps its own pulse-interval (p.i.) counter aligned to the minor cycle (M/C), plus a carry flip-flop, order latch, sign latch and sticky overflow flag.

Parameters:
- INTERVAL, 36, p.i. per minor cycle (counter modulus).
- WORD_BITS, 35, significant bits of a long number; p.i. WORD_BITS-1 is the sign bit.
- SHORT_BITS, 17, significant bits of a short number; sign at p.i. SHORT_BITS-1.

Ports:
- clk  input  1  p.i. clock, one serial bit per edge.
- rst  input  1  asynchronous, active-high reset.
- mc_start  input  1  pulse marking p.i. 0 of a minor cycle; resynchronises the counter.
- acc  input  1  serial accumulator bit, LSB first.
- operand  input  1  serial operand bit from store, LSB first.
- add_en  input  1  A-order: acc + operand this M/C.
- sub_en  input  1  S-order: acc - operand this M/C.
- long_op  input  1  1 = long (35-bit) operand; 0 = short, sign-extended.
- ovf_clr  input  1  synchronous clear of the sticky overflow flag.
- adder_sum  output  1  serial sum bit to the accumulator (combinational from the current inputs and registered state).
- carry  output  1  current carry flip-flop value.
- sign_out  output  1  sign bit of the last completed result.
- overflow  output  1  sticky overflow flag.
- pi  output  6  current p.i. count, 0..INTERVAL-1.

Behaviour:
- Reset (asynchronous, active-high). Clears pi, carry, sign_out, overflow, the order latch (set to NONE) and the short-sign latch; all go to 0. `adder_sum` is held at 0 while rst is high.
- Counter. pi increments each clk and wraps from INTERVAL-1 to 0. If mc_start is high, pi is loaded to 1 on that edge, so the cycle carrying mc_start is treated as p.i. 0. In that cycle the internal p.i.-0 decode is asserted regardless of the pi register.
- Order latch. At p.i. 0, add_en, sub_en and long_op are sampled and held for the whole M/C.
  - add only: ADD.
  - sub only: SUB.
  - neither, or both: NONE (pass-through). Both high is not an error.
- Operand gating, giving b:
  - ADD: b = operand.
  - SUB: b = ~operand.
  - NONE: b = 0.
  - Short operation: at p.i. SHORT_BITS-1 the operand bit is latched as the short sign. For p.i. SHORT_BITS..WORD_BITS-1, the latched sign replaces the operand before inversion.
- Carry-in at p.i. 0: 1 for SUB, 0 otherwise. Any carry left from the previous M/C is discarded.
- Sum and carry, for p.i. 0..WORD_BITS-1:
  - adder_sum = acc ^ b ^ c.
  - Next carry = majority(acc, b, c).
- Guard p.i. (WORD_BITS..INTERVAL-1): adder_sum = 0; carry is forced to 0 on the next edge.
- Overflow, evaluated at p.i. WORD_BITS-1: set when carry-into-sign XOR carry-out-of-sign is 1. It stays set until ovf_clr or rst; if set and ovf_clr occur in the same cycle, set wins.
- sign_out takes adder_sum at p.i. WORD_BITS-1 and holds it until the next p.i. WORD_BITS-1.
- Latency:
  - adder_sum: 0 clk from acc/operand.
  - sign_out and overflow: 1 clk after the sign p.i.
- mc_start mid-cycle (resync):
  - The current word is abandoned; carry restarts per the new order.
  - overflow and sign_out are not updated for the abandoned word.

Decomposition:
- Shared package `edsac_pkg` holds:
  - the order enum {NONE, ADD, SUB};
  - the constants INTERVAL, WORD_BITS, SHORT_BITS;
  - the p.i. width function.
- Natural sub-module: `pulse_counter`, a modulo-INTERVAL counter with mc_start resync and async reset. It can be reused by other serial units.
- The full-adder slice stays inline.

Test Plan:
- Reset mid-cycle: assert rst at p.i. 10 with ADD active -> pi, carry, sign_out, overflow are 0 immediately and adder_sum is 0. After release, pi counts from 0.
- Long ADD: acc=5, operand=3 streamed LSB-first -> adder_sum serialises 8; carry is 0 at guard; sign_out=0; overflow=0.
- Long SUB: acc=3, operand=5 -> result is -2 in 35-bit two's complement (0x7FFFFFFFE); sign_out=1; overflow=0.
- Overflow:
  - ADD acc=2^34-1, operand=1 -> overflow=1 one clk after the sign p.i.
  - It stays 1 over the next two M/Cs.
  - ovf_clr then clears it; ovf_clr together with a new overflow keeps it 1.
- Short sign extension: long_op=0, operand short value -1 (bits 0..16 all 1), acc=0 -> full 35-bit result is -1 (all ones); sign_out=1.
- Order edge cases:
  - add_en=sub_en=1 -> adder_sum equals acc.
  - mc_start pulsed at p.i. 20 -> pi becomes 1 on the next edge, carry restarts, sign_out unchanged.
